instr_controller: RTL and testbench

//  Moore FSM that sequences the 16-bit datapath (regfile, A/B/C regs, shifter, ALU, status).

---
 rtl/ctrl_pkg.sv | 39 +++
 rtl/instr_decoder.sv | 42 ++++
 rtl/instr_controller.sv | 198 +++++++++++++++++++
 tb/tb_instr_controller.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
`default_nettype none
// ctrl_pkg: shared state/class types and the fixed 16-bit ISA field layout.
// Revision: 1.0
package ctrl_pkg;

  localparam int ISA_W   = 16;
  localparam int REG_W   = 3;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int OP_MSB  = 12;
  localparam int OP_LSB  = 11;
  localparam int RN_MSB  = 10;
  localparam int RN_LSB  = 8;
  localparam int RD_MSB  = 7;
  localparam int RD_LSB  = 5;
  localparam int SH_MSB  = 4;
  localparam int SH_LSB  = 3;
  localparam int RM_MSB  = 2;
  localparam int RM_LSB  = 0;
  localparam int IMM_MSB = 7;

  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_MVN     = 2'b11;

  typedef enum logic [2:0] {
    WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_RD, ERR
  } state_t;

  typedef enum logic [2:0] {
    CLS_ILLEGAL, CLS_MOV_IMM, CLS_MOV_REG, CLS_ALU_AB, CLS_MVN
  } iclass_t;

endpackage
`default_nettype wire

// File: rtl/instr_decoder.sv
`default_nettype none
// instr_decoder: combinational field extraction, sign-extended imm8 and instruction class.
// Revision: 1.0
module instr_decoder
  import ctrl_pkg::*;
(
  input  logic [ISA_W-1:0] ir_i,
  output logic [REG_W-1:0] rn_o,
  output logic [REG_W-1:0] rd_o,
  output logic [REG_W-1:0] rm_o,
  output logic [1:0]       op_o,
  output logic [1:0]       sh_o,
  output logic [ISA_W-1:0] sximm8_o,
  output iclass_t          cls_o,
  output logic             legal_o
);

  logic [2:0] opc;

  assign opc      = ir_i[OPC_MSB:OPC_LSB];
  assign op_o     = ir_i[OP_MSB:OP_LSB];
  assign rn_o     = ir_i[RN_MSB:RN_LSB];
  assign rd_o     = ir_i[RD_MSB:RD_LSB];
  assign sh_o     = ir_i[SH_MSB:SH_LSB];
  assign rm_o     = ir_i[RM_MSB:RM_LSB];
  assign sximm8_o = {{(ISA_W-IMM_MSB-1){ir_i[IMM_MSB]}}, ir_i[IMM_MSB:0]};

  // MVN shares the ALU opcode but skips the A-operand fetch, so it gets its own class
  always_comb begin
    cls_o = CLS_ILLEGAL;
    if (opc == OPC_MOV && op_o == OP_MOV_IMM)
      cls_o = CLS_MOV_IMM;
    else if (opc == OPC_MOV && op_o == OP_MOV_REG)
      cls_o = CLS_MOV_REG;
    else if (opc == OPC_ALU)
      cls_o = (op_o == OP_MVN) ? CLS_MVN : CLS_ALU_AB;
  end

  assign legal_o = (cls_o != CLS_ILLEGAL);

endmodule
`default_nettype wire

// File: rtl/instr_controller.sv
`default_nettype none
// instr_controller: Moore FSM sequencing the 16-bit datapath; optional CTRL_ERR_EN adds err/ERR trap.
// Revision: 1.0
module instr_controller
  import ctrl_pkg::*;
#(
  parameter int DW = ISA_W,
  parameter int RW = REG_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s,
  input  logic          load,
  input  logic [DW-1:0] in,
  output logic          w,
  output logic [RW-1:0] readnum,
  output logic [RW-1:0] writenum,
  output logic          write,
  output logic          loada,
  output logic          loadb,
  output logic          loadc,
  output logic          loads,
  output logic          vsel,
  output logic          asel,
  output logic          bsel,
  output logic [1:0]    ALUop,
  output logic [1:0]    shift,
`ifdef CTRL_ERR_EN
  output logic          err,
`endif
  output logic [DW-1:0] datapath_in
);

  state_t        state_q, state_d;
  logic [DW-1:0] ir_q;

  logic [RW-1:0] rn, rd, rm;
  logic [1:0]    op, sh;
  iclass_t       cls;
  logic          legal;

  logic          w_q, w_d;
  logic [RW-1:0] readnum_q, readnum_d, writenum_q, writenum_d;
  logic          write_q, write_d, loada_q, loada_d, loadb_q, loadb_d;
  logic          loadc_q, loadc_d, loads_q, loads_d;
  logic          vsel_q, vsel_d, asel_q, asel_d, bsel_q, bsel_d;
  logic [1:0]    aluop_q, aluop_d, shift_q, shift_d;
`ifdef CTRL_ERR_EN
  logic          err_q, err_d;
`endif

  instr_decoder u_dec (
    .ir_i     (ir_q),
    .rn_o     (rn),
    .rd_o     (rd),
    .rm_o     (rm),
    .op_o     (op),
    .sh_o     (sh),
    .sximm8_o (datapath_in),
    .cls_o    (cls),
    .legal_o  (legal)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT:      if (s) state_d = DECODE;
      DECODE: begin
        if (!legal) begin
`ifdef CTRL_ERR_EN
          state_d = ERR;
`else
          state_d = WAIT;
`endif
        end else if (cls == CLS_MOV_IMM) state_d = WRITE_IMM;
        else if (cls == CLS_ALU_AB)      state_d = GET_A;
        else                             state_d = GET_B;
      end
      WRITE_IMM: state_d = WAIT;
      GET_A:     state_d = GET_B;
      GET_B:     state_d = ALU;
      ALU:       state_d = (cls == CLS_ALU_AB && op == OP_CMP) ? WAIT : WRITE_RD;
      WRITE_RD:  state_d = WAIT;
`ifdef CTRL_ERR_EN
      ERR:       state_d = ERR;
`endif
      default:   state_d = WAIT;
    endcase
  end

  // Outputs are decoded from the state being entered so they register alongside it
  always_comb begin
    w_d        = (state_d == WAIT);
    readnum_d  = '0;
    writenum_d = '0;
    write_d    = 1'b0;
    loada_d    = 1'b0;
    loadb_d    = 1'b0;
    loadc_d    = 1'b0;
    loads_d    = 1'b0;
    vsel_d     = 1'b0;
    asel_d     = 1'b0;
    bsel_d     = 1'b0;
    aluop_d    = 2'b00;
    shift_d    = 2'b00;
`ifdef CTRL_ERR_EN
    err_d      = (state_d == ERR);
`endif
    case (state_d)
      WRITE_IMM: begin
        writenum_d = rn;
        vsel_d     = 1'b1;
        write_d    = 1'b1;
      end
      GET_A: begin
        readnum_d = rn;
        loada_d   = 1'b1;
      end
      GET_B: begin
        readnum_d = rm;
        loadb_d   = 1'b1;
      end
      ALU: begin
        shift_d = sh;
        asel_d  = (cls == CLS_MOV_REG || cls == CLS_MVN);
        aluop_d = op;
        if (cls == CLS_ALU_AB && op == OP_CMP) loads_d = 1'b1;
        else                                   loadc_d = 1'b1;
      end
      WRITE_RD: begin
        writenum_d = rd;
        write_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= WAIT;
      ir_q       <= '0;
      w_q        <= 1'b1;
      readnum_q  <= '0;
      writenum_q <= '0;
      write_q    <= 1'b0;
      loada_q    <= 1'b0;
      loadb_q    <= 1'b0;
      loadc_q    <= 1'b0;
      loads_q    <= 1'b0;
      vsel_q     <= 1'b0;
      asel_q     <= 1'b0;
      bsel_q     <= 1'b0;
      aluop_q    <= 2'b00;
      shift_q    <= 2'b00;
`ifdef CTRL_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      if (load && state_q == WAIT) ir_q <= in;
      w_q        <= w_d;
      readnum_q  <= readnum_d;
      writenum_q <= writenum_d;
      write_q    <= write_d;
      loada_q    <= loada_d;
      loadb_q    <= loadb_d;
      loadc_q    <= loadc_d;
      loads_q    <= loads_d;
      vsel_q     <= vsel_d;
      asel_q     <= asel_d;
      bsel_q     <= bsel_d;
      aluop_q    <= aluop_d;
      shift_q    <= shift_d;
`ifdef CTRL_ERR_EN
      err_q      <= err_d;
`endif
    end
  end

  assign w        = w_q;
  assign readnum  = readnum_q;
  assign writenum = writenum_q;
  assign write    = write_q;
  assign loada    = loada_q;
  assign loadb    = loadb_q;
  assign loadc    = loadc_q;
  assign loads    = loads_q;
  assign vsel     = vsel_q;
  assign asel     = asel_q;
  assign bsel     = bsel_q;
  assign ALUop    = aluop_q;
  assign shift    = shift_q;
`ifdef CTRL_ERR_EN
  assign err      = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_controller.sv
`default_nettype none
// tb_instr_controller: directed + randomized instructions checked cycle by cycle against a step-list model.
// Revision: 1.0
module tb_instr_controller;

  typedef struct packed {
    logic       w;
    logic [2:0] rdn;
    logic [2:0] wrn;
    logic       write, loada, loadb, loadc, loads, vsel, asel, bsel;
    logic [1:0] aluop;
    logic [1:0] shift;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, s, load;
  logic [15:0] instr_in;
  logic        w, write, loada, loadb, loadc, loads, vsel, asel, bsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  ALUop, shift;
  logic [15:0] datapath_in;
`ifdef CTRL_ERR_EN
  logic        err;
`endif

  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] ir_model;
  vec_t        exp_q[$];
  int          busy;

  instr_controller dut (
    .clk         (clk),
    .reset       (reset),
    .s           (s),
    .load        (load),
    .in          (instr_in),
    .w           (w),
    .readnum     (readnum),
    .writenum    (writenum),
    .write       (write),
    .loada       (loada),
    .loadb       (loadb),
    .loadc       (loadc),
    .loads       (loads),
    .vsel        (vsel),
    .asel        (asel),
    .bsel        (bsel),
    .ALUop       (ALUop),
    .shift       (shift),
`ifdef CTRL_ERR_EN
    .err         (err),
`endif
    .datapath_in (datapath_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic vec_t obs();
    vec_t v;
    v.w = w; v.rdn = readnum; v.wrn = writenum;
    v.write = write; v.loada = loada; v.loadb = loadb; v.loadc = loadc;
    v.loads = loads; v.vsel = vsel; v.asel = asel; v.bsel = bsel;
    v.aluop = ALUop; v.shift = shift;
    return v;
  endfunction

  function automatic logic [15:0] sext8(input logic [15:0] ir);
    return (ir & 16'h0080) != 0 ? (ir | 16'hFF00) : (ir & 16'h00FF);
  endfunction

  // Expected control vector for every cycle from DECODE back to WAIT
  function automatic void build(input logic [15:0] ir);
    int   opc, op;
    bit   mov_imm, mov_reg, alu;
    vec_t z, v;
    opc = int'(ir >> 13) & 7;
    op  = int'(ir >> 11) & 3;
    mov_imm = (opc == 6) && (op == 2);
    mov_reg = (opc == 6) && (op == 0);
    alu     = (opc == 5);
    z = '0;
    exp_q.delete();
    exp_q.push_back(z);
    if (mov_imm) begin
      v = z; v.wrn = 3'((ir >> 8) & 16'h7); v.vsel = 1; v.write = 1; exp_q.push_back(v);
    end else if (mov_reg || alu) begin
      if (alu && op != 3) begin
        v = z; v.rdn = 3'((ir >> 8) & 16'h7); v.loada = 1; exp_q.push_back(v);
      end
      v = z; v.rdn = 3'(ir & 16'h7); v.loadb = 1; exp_q.push_back(v);
      v = z; v.shift = 2'((ir >> 3) & 16'h3); v.aluop = 2'(op);
      v.asel = mov_reg || op == 3;
      if (alu && op == 1) v.loads = 1; else v.loadc = 1;
      exp_q.push_back(v);
      if (!(alu && op == 1)) begin
        v = z; v.wrn = 3'((ir >> 5) & 16'h7); v.write = 1; exp_q.push_back(v);
      end
    end
    z.w = 1;
    exp_q.push_back(z);
  endfunction

  task automatic run_instr(input logic [15:0] instr, input bit do_load, input bit noise,
                           input bit hold_s, output int nbusy);
    if (do_load) ir_model = instr;
    build(ir_model);
    @(negedge clk);
    instr_in = instr; load = do_load; s = 1'b1;
    @(posedge clk); #1;
    s = hold_s; load = noise; instr_in = ~instr;
    nbusy = 0;
    foreach (exp_q[i]) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (!w) nbusy++;
      chk("ctrl", 32'(obs()), 32'(exp_q[i]));
      chk("dpin", 32'(datapath_in), 32'(sext8(ir_model)));
    end
    load = 1'b0;
  endtask

  function automatic logic [15:0] rand_instr(input bit allow_illegal);
    logic [15:0] r;
    int k;
    r = 16'($urandom);
    k = allow_illegal ? $urandom_range(0, 6) : $urandom_range(0, 5);
    case (k)
      0: r[15:11] = 5'b11010;
      1: r[15:11] = 5'b11000;
      6: begin
        if (r[15:13] == 3'b101) r[15:13] = 3'b111;
        if (r[15:13] == 3'b110) r[11] = 1'b1;
      end
      default: r[15:13] = 3'b101;
    endcase
    return r;
  endfunction

`ifdef CTRL_ERR_EN
  task automatic err_run(input logic [15:0] instr, input bit do_load);
    @(negedge clk);
    instr_in = instr; load = do_load; s = 1'b1;
    @(posedge clk); #1;
    s = 1'b0; load = 1'b0;
    chk("err_decode_w", 32'(w), 0);
    @(posedge clk); #1;
    chk("err_flag", 32'(err), 1);
    chk("err_ctrl", 32'(obs()), 0);
    repeat (3) @(posedge clk);
    #1 chk("err_hold", 32'({err, w}), 32'h2);
    #2 reset = 1'b1;
    #1 chk("err_reset", 32'({err, w}), 32'h1);
    @(negedge clk) reset = 1'b0;
    ir_model = '0;
  endtask
`endif

  initial begin
    vec_t idle;
    idle = '0; idle.w = 1'b1;
    reset = 1'b1; s = 1'b0; load = 1'b0; instr_in = '0; ir_model = '0;
    #12;
    chk("reset_ctrl", 32'(obs()), 32'(idle));
    chk("reset_dpin", 32'(datapath_in), 0);
`ifdef CTRL_ERR_EN
    chk("reset_err", 32'(err), 0);
`endif
    @(negedge clk) reset = 1'b0;

    run_instr(16'hD007, 1, 0, 0, busy); chk("mov_imm_busy", busy, 2);
    chk("imm_pos", 32'(datapath_in), 32'h0007);
    run_instr(16'hD1FE, 1, 0, 0, busy); chk("mov_neg_busy", busy, 2);
    chk("imm_neg", 32'(datapath_in), 32'hFFFE);
    run_instr(16'hA148, 1, 1, 0, busy); chk("add_busy", busy, 5);
    chk("ir_kept", 32'(datapath_in), 32'h0048);
    run_instr(16'hA801, 1, 0, 0, busy); chk("cmp_busy", busy, 4);
    run_instr(16'hB8E3, 1, 0, 0, busy); chk("mvn_busy", busy, 4);
    run_instr(16'hC0B9, 1, 0, 0, busy); chk("movreg_busy", busy, 4);

    // s held high restarts on the edge after reaching WAIT
    run_instr(16'hD007, 1, 0, 1, busy);
    @(posedge clk); #1;
    chk("s_hold_restart", 32'(w), 0);
    s = 1'b0;
    for (int i = 0; i < 8 && !w; i++) begin @(posedge clk); #1; end
    chk("s_hold_done", 32'(w), 1);

    // asynchronous reset in GET_B of ADD
    @(negedge clk);
    instr_in = 16'hA148; load = 1'b1; s = 1'b1;
    @(posedge clk); #1 s = 1'b0; load = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("getb_loadb", 32'({loadb, readnum}), 32'h8);
    #2 reset = 1'b1;
    #1 chk("async_reset_ctrl", 32'(obs()), 32'(idle));
    chk("async_reset_ir", 32'(datapath_in), 0);
    @(negedge clk) reset = 1'b0;
    ir_model = '0;

`ifdef CTRL_ERR_EN
    err_run(16'h0000, 0);
    err_run(16'hE000, 1);
`else
    run_instr(16'h0000, 0, 0, 0, busy); chk("rerun_ir0_busy", busy, 1);
    run_instr(16'hE000, 1, 0, 0, busy); chk("illegal_busy", busy, 1);
`endif

    for (int n = 0; n < 60; n++) begin
`ifdef CTRL_ERR_EN
      run_instr(rand_instr(0), $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, 0, busy);
`else
      run_instr(rand_instr(1), $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, 0, busy);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
